// File: rtl/spi_pkg.sv
// Shared definitions for the SPI masters: FSM state encoding, CPOL/CPHA constants
// and an elaboration-time parameter legality check.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SS_SETUP,
    ST_XFER_LEAD,
    ST_XFER_TRAIL,
    ST_SS_HOLD,
    ST_DONE
  } spi_state_e;

  localparam int CPOL_IDLE_LOW     = 0;
  localparam int CPOL_IDLE_HIGH    = 1;
  localparam int CPHA_SAMPLE_LEAD  = 0;
  localparam int CPHA_SAMPLE_TRAIL = 1;

  localparam int SPI_WID_MIN = 2;
  localparam int SPI_WID_MAX = 32;

  function automatic bit spi_params_legal(int wid, int wid_len, int timer_len,
                                          int half_wait, int ss_wait,
                                          int polarity, int phase);
    bit ok;
    ok = 1'b1;
    if (wid < SPI_WID_MIN || wid > SPI_WID_MAX) ok = 1'b0;
    if (wid_len < 1 || wid_len > 30 || (1 << wid_len) <= wid) ok = 1'b0;
    if (timer_len < 1 || timer_len > 30) ok = 1'b0;
    else begin
      if (half_wait < 0 || half_wait >= (1 << timer_len)) ok = 1'b0;
      if (ss_wait < 1 || ss_wait >= (1 << timer_len)) ok = 1'b0;
    end
    if (polarity != CPOL_IDLE_LOW && polarity != CPOL_IDLE_HIGH) ok = 1'b0;
    if (phase != CPHA_SAMPLE_LEAD && phase != CPHA_SAMPLE_TRAIL) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/spi_half_period_timer.sv
// Loadable down-counter; a load of N produces a one-cycle tick N+1 cycles later.
module spi_half_period_timer #(
  parameter int TIMER_LEN = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [TIMER_LEN-1:0] load_val_i,
  output logic                 tick_o
);

  logic [TIMER_LEN-1:0] cnt_q;
  logic                 active_q;

  assign tick_o = active_q && (cnt_q == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (load_i) begin
      cnt_q    <= load_val_i;
      active_q <= 1'b1;
    end else if (active_q) begin
      if (cnt_q == '0) active_q <= 1'b0;
      else             cnt_q    <= cnt_q - TIMER_LEN'(1);
    end
  end

endmodule

// File: rtl/spi_master_port.sv
// Fixed-mode SPI master driving one crossbar port with an arm/finished handshake.
// Build option SPI_MASTER_ABORT_EN: dropping arm mid-transfer aborts to IDLE.
module spi_master_port
  import spi_pkg::*;
#(
  parameter int WID             = 24,
  parameter int WID_LEN         = 5,
  parameter int CYCLE_HALF_WAIT = 1,
  parameter int TIMER_LEN       = 3,
  parameter int POLARITY        = 0,
  parameter int PHASE           = 0,
  parameter int SS_WAIT         = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           arm,
  output logic           ready_to_arm,
  output logic           finished,
  input  logic [WID-1:0] to_slave,
  output logic [WID-1:0] from_slave,
  output logic           mosi,
  input  logic           miso,
  output logic           sck_wire,
  output logic           ss_L
);

  // state       | meaning
  // IDLE        | ready_to_arm high, waiting for arm
  // SS_SETUP    | ss_L low, sck idle, SS_WAIT+1 cycles before first edge
  // XFER_LEAD   | sck at !POLARITY for one half-period
  // XFER_TRAIL  | sck at POLARITY for one half-period
  // SS_HOLD     | sck idle, SS_WAIT+1 cycles before ss_L release
  // DONE        | finished high until arm drops
  localparam logic SCK_IDLE    = (POLARITY != CPOL_IDLE_LOW);
  localparam bit   SAMPLE_LEAD = (PHASE == CPHA_SAMPLE_LEAD);

  if (!spi_params_legal(WID, WID_LEN, TIMER_LEN, CYCLE_HALF_WAIT, SS_WAIT,
                        POLARITY, PHASE)) begin : g_param_check
    $error("spi_master_port: illegal parameter combination");
  end

  spi_state_e           state_q;
  logic [WID-1:0]       tx_q, rx_q;
  logic [WID_LEN-1:0]   bit_cnt_q;
  logic                 sck_q, mosi_q, ss_l_q, finished_q, ready_q;

  logic                 tmr_load, tmr_tick;
  logic [TIMER_LEN-1:0] tmr_val;
  logic                 accept, abort, last_bit;
  logic                 lead_enter, trail_enter, hold_enter, sample_now, shift_now;
  logic [WID-1:0]       tx_shift_d, rx_shift_d;

  always_comb begin
    accept = (state_q == ST_IDLE) && arm;
`ifdef SPI_MASTER_ABORT_EN
    abort = !arm && (state_q inside {ST_SS_SETUP, ST_XFER_LEAD, ST_XFER_TRAIL});
`else
    abort = 1'b0;
`endif
    last_bit    = (bit_cnt_q == WID_LEN'(WID));
    lead_enter  = tmr_tick && !abort &&
                  ((state_q == ST_SS_SETUP) || (state_q == ST_XFER_TRAIL && !last_bit));
    trail_enter = tmr_tick && !abort && (state_q == ST_XFER_LEAD);
    hold_enter  = tmr_tick && !abort && (state_q == ST_XFER_TRAIL) && last_bit;
    sample_now  = SAMPLE_LEAD ? lead_enter  : trail_enter;
    shift_now   = SAMPLE_LEAD ? trail_enter : lead_enter;
    tmr_load    = accept || lead_enter || trail_enter || hold_enter;
    tmr_val     = (accept || hold_enter) ? TIMER_LEN'(SS_WAIT) : TIMER_LEN'(CYCLE_HALF_WAIT);
    tx_shift_d  = {tx_q[WID-2:0], 1'b0};
    rx_shift_d  = {rx_q[WID-2:0], miso};
  end

  spi_half_period_timer #(.TIMER_LEN(TIMER_LEN)) u_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tick_o     (tmr_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tx_q       <= '0;
      rx_q       <= '0;
      bit_cnt_q  <= '0;
      sck_q      <= SCK_IDLE;
      mosi_q     <= 1'b0;
      ss_l_q     <= 1'b1;
      finished_q <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      if (sample_now) begin
        rx_q      <= rx_shift_d;
        bit_cnt_q <= bit_cnt_q + WID_LEN'(1);
      end
      // CPHA=0 already has the current bit on mosi, so it advances to the next one
      if (shift_now) begin
        mosi_q <= SAMPLE_LEAD ? tx_shift_d[WID-1] : tx_q[WID-1];
        tx_q   <= tx_shift_d;
      end
      if (lead_enter) begin
        state_q <= ST_XFER_LEAD;
        sck_q   <= ~SCK_IDLE;
      end
      if (trail_enter) begin
        state_q <= ST_XFER_TRAIL;
        sck_q   <= SCK_IDLE;
      end
      if (hold_enter) state_q <= ST_SS_HOLD;

      case (state_q)
        ST_IDLE: if (arm) begin
          state_q   <= ST_SS_SETUP;
          tx_q      <= to_slave;
          rx_q      <= '0;
          bit_cnt_q <= '0;
          ss_l_q    <= 1'b0;
          ready_q   <= 1'b0;
          mosi_q    <= SAMPLE_LEAD ? to_slave[WID-1] : 1'b0;
        end
        ST_SS_HOLD: if (tmr_tick) begin
          state_q    <= ST_DONE;
          ss_l_q     <= 1'b1;
          mosi_q     <= 1'b0;
          finished_q <= 1'b1;
        end
        ST_DONE: if (!arm) begin
          state_q    <= ST_IDLE;
          finished_q <= 1'b0;
          ready_q    <= 1'b1;
        end
        default: ;
      endcase

      if (abort) begin
        state_q   <= ST_IDLE;
        sck_q     <= SCK_IDLE;
        ss_l_q    <= 1'b1;
        mosi_q    <= 1'b0;
        ready_q   <= 1'b1;
        rx_q      <= '0;
        bit_cnt_q <= '0;
      end
    end
  end

  assign ready_to_arm = ready_q;
  assign finished     = finished_q;
  assign from_slave   = rx_q;
  assign mosi         = mosi_q;
  assign sck_wire     = sck_q;
  assign ss_L         = ss_l_q;

endmodule
